// File: rtl/data_launch_capture.sv
// data_launch_capture
//   Launches stimulus bytes into the combinational logic-cell datapath and
//   captures its 5-bit response. Incoming bytes are queued in a small FIFO,
//   each popped byte is held on cell_data for SETTLE cycles, and then the
//   response is sampled and presented as {byte, response} on a valid/ready
//   result port.
//
// Parameters
//   DEPTH   input FIFO depth in bytes (power of 2, >= 2)
//   SETTLE  cycles cell_data is held before cell_resp is sampled (1..255)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   stimulus byte handshake, in_data = byte
//   cell_data           registered drive to datapath data[7:0]
//   cell_resp           datapath response, bit0=out1 ... bit4=out5
//   res_valid/res_ready result handshake, res_data = {byte, response}
//   busy                launch/hold in progress or FIFO non-empty
//
// Optional feature (macro DATA_LAUNCH_STATS_EN)
//   done_count[15:0]    saturating count of completed result handshakes
//   overflow_seen[0:0]  sticky flag: in_valid seen while in_ready was low
module data_launch_capture #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  cell_data,
  input  logic [4:0]  cell_resp,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [12:0] res_data,
`ifdef DATA_LAUNCH_STATS_EN
  output logic [15:0] done_count,
  output logic [0:0]  overflow_seen,
`endif
  output logic        busy
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [7:0]  RELOAD  = 8'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, fill;
  logic [7:0]  cnt;
  logic        full, empty, push, pop, capture, retire;

  assign fill     = wptr - rptr;
  assign full     = (fill == DEPTH_W);
  assign empty    = (wptr == rptr);
  assign in_ready = ~full;
  // Push depends only on the registered full flag, so a simultaneous pop
  // never lets a byte slip into a full FIFO.
  assign push     = in_valid & ~full;
  assign busy     = (state != IDLE) | ~empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          retire = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      cell_data <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr      <= rptr + 1'b1;
        cell_data <= mem[rptr[AW-1:0]];
        cnt       <= RELOAD;
      end else if (state == LAUNCH && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        res_data  <= {cell_data, cell_resp};
        res_valid <= 1'b1;
      end else if (retire) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef DATA_LAUNCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count    <= '0;
      overflow_seen <= '0;
    end else begin
      if (retire && done_count != '1) done_count <= done_count + 1'b1;
      if (in_valid && full) overflow_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_launch_capture.sv
// Directed self-checking bench for data_launch_capture (DEPTH=4, SETTLE=2).
// The datapath stub returns cell_data[4:0] ^ 5'h1F combinationally.
module tb_data_launch_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  cell_data;
  logic [4:0]  cell_resp;
  logic        res_valid;
  logic        res_ready;
  logic [12:0] res_data;
  logic        busy;
`ifdef DATA_LAUNCH_STATS_EN
  logic [15:0] done_count;
  logic [0:0]  overflow_seen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cell_resp = cell_data[4:0] ^ 5'h1F;

  data_launch_capture #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cell_data(cell_data), .cell_resp(cell_resp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef DATA_LAUNCH_STATS_EN
    .done_count(done_count), .overflow_seen(overflow_seen),
`endif
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] expect_res(input logic [7:0] b);
    logic [4:0] r;
    r = b[4:0] ^ 5'h1F;
    return {b, r};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int vcyc[$];
    logic [12:0] vdat[$];
    logic [7:0] b;
    logic [12:0] held;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

    // 1. reset then idle
    repeat (3) tick();
    chk("rst_cell_data", 32'(cell_data), 32'h00);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data",  32'(res_data),  32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_cell_data", 32'(cell_data), 32'h00);
      chk("idle_res_valid", 32'(res_valid), 32'h0);
      chk("idle_in_ready",  32'(in_ready),  32'h1);
      chk("idle_busy",      32'(busy),      32'h0);
    end

    // 2. single byte latency
    in_valid = 1'b1; in_data = 8'hA5; res_ready = 1'b1;
    tick();                                   // edge N: accepted
    in_valid = 1'b0;
    chk("s_cell_data_N", 32'(cell_data), 32'h00);
    chk("s_busy_N",      32'(busy),      32'h1);
    tick();                                   // N+1
    chk("s_cell_data_N1", 32'(cell_data), 32'hA5);
    chk("s_valid_N1",     32'(res_valid), 32'h0);
    tick();                                   // N+2
    chk("s_valid_N2",     32'(res_valid), 32'h0);
    tick();                                   // N+3
    chk("s_valid_N3",     32'(res_valid), 32'h1);
    chk("s_data_N3",      32'(res_data),  32'({8'hA5, 5'h1A}));
    tick();                                   // N+4: handshake taken
    chk("s_valid_N4",     32'(res_valid), 32'h0);
    chk("s_busy_N4",      32'(busy),      32'h0);
    chk("s_cell_keep",    32'(cell_data), 32'hA5);

    // 3. back-pressure and full FIFO
    res_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      chk("bp_in_ready", 32'(in_ready), (i <= 5) ? 32'h1 : 32'h0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_cell_data", 32'(cell_data), 32'h01);
    for (int k = 0; k < 5; k++) begin
      b = 8'(k + 1);
      res_ready = 1'b0;
      t = 0;
      while (!res_valid && t < 10) begin tick(); t++; end
      chk("bp_wait_valid", 32'(res_valid), 32'h1);
      chk("bp_data", 32'(res_data), 32'(expect_res(b)));
      held = res_data;
      tick();
      chk("bp_hold_valid", 32'(res_valid), 32'h1);
      chk("bp_hold_data",  32'(res_data),  32'(held));
      res_ready = 1'b1;
      tick();
      chk("bp_consumed", 32'(res_valid), 32'h0);
    end
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_no_extra", 32'(res_valid), 32'h0);
    end
    chk("bp_busy_end", 32'(busy), 32'h0);

    // 4. back-to-back throughput
    res_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h10; tick();
    in_data = 8'h20; tick();
    in_data = 8'h30; tick();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (res_valid) begin
        vcyc.push_back(c);
        vdat.push_back(res_data);
      end
    end
    chk("tp_count", 32'(vcyc.size()), 32'd3);
    if (vcyc.size() == 3) begin
      chk("tp_r0", 32'(vdat[0]), 32'({8'h10, 5'h0F}));
      chk("tp_r1", 32'(vdat[1]), 32'({8'h20, 5'h1F}));
      chk("tp_r2", 32'(vdat[2]), 32'({8'h30, 5'h0F}));
      chk("tp_gap1", 32'(vcyc[1] - vcyc[0]), 32'd3);
      chk("tp_gap2", 32'(vcyc[2] - vcyc[1]), 32'd3);
    end

    // 5. reset mid-launch
    in_valid = 1'b1; in_data = 8'hFF; tick();
    in_valid = 1'b0; tick();                  // popped: LAUNCH
    chk("mr_cell_launch", 32'(cell_data), 32'hFF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_cell_data", 32'(cell_data), 32'h00);
    chk("mr_res_valid", 32'(res_valid), 32'h0);
    chk("mr_res_data",  32'(res_data),  32'h0);
    chk("mr_busy",      32'(busy),      32'h0);
    chk("mr_in_ready",  32'(in_ready),  32'h1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_no_result", 32'(res_valid), 32'h0);
      chk("mr_cell_zero", 32'(cell_data), 32'h00);
    end

`ifdef DATA_LAUNCH_STATS_EN
    // 6. statistics
    chk("st_done0", 32'(done_count), 32'd0);
    chk("st_ovf0",  32'(overflow_seen), 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i); tick();
    end
    in_valid = 1'b0;
    repeat (15) tick();
    chk("st_done3", 32'(done_count), 32'd3);
    res_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i); tick();
    end
    in_valid = 1'b0;
    chk("st_ovf_set", 32'(overflow_seen), 32'd1);
    res_ready = 1'b1;
    repeat (25) tick();
    chk("st_ovf_sticky", 32'(overflow_seen), 32'd1);
    chk("st_done8", 32'(done_count), 32'd8);
    rst_n = 1'b0; #1;
    chk("st_ovf_rst",  32'(overflow_seen), 32'd0);
    chk("st_done_rst", 32'(done_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
